// File: rtl/vpu_pkg.sv
// Shared definitions for the video capture block: geometry defaults, capture
// state encoding and the CRC-32 step function used by the optional frame CRC.
package vpu_pkg;

   localparam int SCREEN_W_DEF = 320;
   localparam int SCREEN_H_DEF = 240;

   localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
   localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } cap_state_t;

   // One full 32-bit word folded in MSB-first, no reflection, no final XOR.
   function automatic logic [31:0] crc32_next(input logic [31:0] crc,
                                              input logic [31:0] data);
      logic [31:0] c;
      c = crc;
      for (int i = 31; i >= 0; i--) begin
         if (c[31] ^ data[i]) c = (c << 1) ^ CRC_POLY;
         else                 c = c << 1;
      end
      return c;
   endfunction

endpackage

// File: rtl/vpu_crc32.sv
// Registered CRC-32 accumulator, one 32-bit word per cycle; init restarts the
// sum and may coincide with the first word.
module vpu_crc32
   import vpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        init,
   input  logic        en,
   input  logic [31:0] data,
   output logic [31:0] crc
);

   always_ff @(posedge clk) begin
      if (rst)       crc <= '0;
      else if (en)   crc <= crc32_next(init ? CRC_INIT : crc, data);
      else if (init) crc <= CRC_INIT;
   end

endmodule

// File: rtl/vpu_capture.sv
// Frame grabber: aligns sync with lagging pixel data and writes one visible frame
// linearly into a framebuffer. Define VPU_CAPTURE_CRC_EN to add the frame_crc output.
module vpu_capture
   import vpu_pkg::*;
#(
   parameter int SCREEN_W      = SCREEN_W_DEF,
   parameter int SCREEN_H      = SCREEN_H_DEF,
   parameter int PIXEL_LATENCY = 4,
   parameter int FB_ADDR_W     = 17
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          color,
   input  logic                 hsync,
   input  logic                 vsync,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 continuous,
   output logic                 fb_en,
   output logic                 fb_we,
   output logic [FB_ADDR_W-1:0] fb_addr,
   output logic [31:0]          fb_din,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 err,
`ifdef VPU_CAPTURE_CRC_EN
   output logic [31:0]          frame_crc,
`endif
   output cap_state_t           dbg_state
);

   localparam logic [FB_ADDR_W:0] TOTAL  = (FB_ADDR_W+1)'(SCREEN_W * SCREEN_H);
   localparam logic [15:0]        LINE_W = 16'(SCREEN_W);
   localparam logic [15:0]        LINES  = 16'(SCREEN_H);

   cap_state_t             state;
   logic [PIXEL_LATENCY-1:0] hs_sr, vs_sr;
   logic                   hs_d, vs_d, hs_q, vs_q;
   logic [FB_ADDR_W:0]     addr_cnt;
   logic [15:0]            px_cnt, line_cnt, lines_now;
   logic                   vs_rise, vs_fall, hs_fall;
   logic                   frame_start, in_frame, pix_valid, overflow, wr_req;
   logic                   line_end, frame_end;

   assign hs_d = hs_sr[PIXEL_LATENCY-1];
   assign vs_d = vs_sr[PIXEL_LATENCY-1];

   assign vs_rise = vs_d & ~vs_q;
   assign vs_fall = ~vs_d & vs_q;
   assign hs_fall = ~hs_d & hs_q;

   // The first pixel may share its cycle with the vs_d rise, so that cycle already counts.
   assign frame_start = (state == ST_ARMED) && vs_rise && !stop;
   assign in_frame    = ((state == ST_CAPTURE) && !stop) || frame_start;
   assign pix_valid   = in_frame && hs_d && vs_d;
   assign overflow    = pix_valid && (addr_cnt >= TOTAL);
   assign wr_req      = pix_valid && !overflow;
   assign line_end    = (state == ST_CAPTURE) && !stop && hs_fall && vs_q;
   assign frame_end   = (state == ST_CAPTURE) && !stop && vs_fall;
   assign lines_now   = line_cnt + (line_end ? 16'd1 : 16'd0);

   assign busy       = (state == ST_ARMED) || (state == ST_CAPTURE);
   assign frame_done = (state == ST_DONE);
   assign dbg_state  = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         hs_sr <= '0;
         vs_sr <= '0;
         hs_q  <= 1'b0;
         vs_q  <= 1'b0;
      end else begin
         hs_sr <= (hs_sr << 1) | PIXEL_LATENCY'(hsync);
         vs_sr <= (vs_sr << 1) | PIXEL_LATENCY'(vsync);
         hs_q  <= hs_d;
         vs_q  <= vs_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:    if (start) state <= ST_ARMED;
            ST_ARMED:   if (stop) state <= ST_IDLE;
                        else if (vs_rise) state <= ST_CAPTURE;
            ST_CAPTURE: if (stop) state <= ST_IDLE;
                        else if (vs_fall) state <= ST_DONE;
            default:    state <= continuous ? ST_ARMED : ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fb_en    <= 1'b0;
         fb_we    <= 1'b0;
         fb_addr  <= '0;
         fb_din   <= '0;
         addr_cnt <= '0;
         px_cnt   <= '0;
         line_cnt <= '0;
         err      <= 1'b0;
      end else begin
         fb_en <= wr_req;
         fb_we <= wr_req;
         if (wr_req) begin
            fb_addr <= addr_cnt[FB_ADDR_W-1:0];
            fb_din  <= color;
         end

         // Counters only live inside a frame; clearing them outside means frame start sees 0.
         if (!in_frame)    addr_cnt <= '0;
         else if (wr_req)  addr_cnt <= addr_cnt + 1'b1;

         if (!in_frame)          px_cnt <= '0;
         else if (line_end)      px_cnt <= '0;
         else if (pix_valid)     px_cnt <= px_cnt + 16'd1;

         if (!in_frame)     line_cnt <= '0;
         else if (line_end) line_cnt <= line_cnt + 16'd1;

         if ((state == ST_IDLE) && start)
            err <= 1'b0;
         else if ((line_end && (px_cnt != LINE_W)) || overflow ||
                  (frame_end && (lines_now != LINES)))
            err <= 1'b1;
      end
   end

`ifdef VPU_CAPTURE_CRC_EN
   vpu_crc32 u_crc (
      .clk  (clk),
      .rst  (rst),
      .init (frame_start),
      .en   (wr_req),
      .data (color),
      .crc  (frame_crc)
   );
`endif

endmodule

// File: tb/tb_vpu_capture.sv
// Directed bench for vpu_capture on a 4x2 screen with 4-cycle pixel latency.
module tb_vpu_capture;
   import vpu_pkg::*;

   localparam int SW = 4;
   localparam int SH = 2;
   localparam int PL = 4;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [31:0]   color = '0;
   logic          hsync = 1'b0, vsync = 1'b0;
   logic          start = 1'b0, stop = 1'b0, continuous = 1'b0;
   logic          fb_en, fb_we;
   logic [AW-1:0] fb_addr;
   logic [31:0]   fb_din;
   logic          busy, frame_done, err;
   cap_state_t    dbg_state;
`ifdef VPU_CAPTURE_CRC_EN
   logic [31:0]   frame_crc;
`endif

   vpu_capture #(.SCREEN_W(SW), .SCREEN_H(SH), .PIXEL_LATENCY(PL), .FB_ADDR_W(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .color      (color),
      .hsync      (hsync),
      .vsync      (vsync),
      .start      (start),
      .stop       (stop),
      .continuous (continuous),
      .fb_en      (fb_en),
      .fb_we      (fb_we),
      .fb_addr    (fb_addr),
      .fb_din     (fb_din),
      .busy       (busy),
      .frame_done (frame_done),
      .err        (err),
`ifdef VPU_CAPTURE_CRC_EN
      .frame_crc  (frame_crc),
`endif
      .dbg_state  (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   logic [AW+31:0] exp_q[$];
   int done_cnt = 0;
   int pix_ctr = 0;
   bit zero_col = 1'b0;
   bit req_start = 1'b0;
   bit stop_pend = 1'b0, rst_pend = 1'b0;
   int stop_at_g = 1000, rst_at_g = 1000;
   logic [31:0] cpipe[PL];
   int ipipe[PL];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", tag, got, exp);
      end
   endtask

   // scoreboard: every write must match the head of the expected queue
   always @(negedge clk) begin
      if (frame_done) done_cnt++;
      if (fb_we) begin
         chk("fb_en_with_we", fb_en, 1);
         chk("wr_q_nonempty", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            logic [AW+31:0] e;
            e = exp_q.pop_front();
            chk("wr_addr", fb_addr, e[AW+31:32]);
            chk("wr_data", fb_din, e[31:0]);
         end
      end
   end

   // One cycle of input; color trails sync by PL ticks, idx tags the pixel the DUT sees.
   task automatic tick(input bit hs, input bit vs, input logic [31:0] val, input int idx);
      int cur;
      @(posedge clk); #1;
      color = cpipe[PL-1];
      cur   = ipipe[PL-1];
      for (int i = PL-1; i > 0; i--) begin
         cpipe[i] = cpipe[i-1];
         ipipe[i] = ipipe[i-1];
      end
      cpipe[0] = val;
      ipipe[0] = idx;
      hsync = hs;
      vsync = vs;
      start = req_start;
      req_start = 1'b0;
      stop = (cur >= 0) && (cur == stop_at_g);
      rst  = (cur >= 0) && (cur == rst_at_g);
      @(negedge clk);
      if (stop_pend) begin
         chk("stop_we", fb_we, 0);
         chk("stop_busy", busy, 0);
         chk("stop_done", frame_done, 0);
      end
      if (rst_pend) begin
         chk("rst_en", fb_en, 0);
         chk("rst_we", fb_we, 0);
         chk("rst_addr", fb_addr, 0);
         chk("rst_din", fb_din, 0);
         chk("rst_busy", busy, 0);
         chk("rst_done", frame_done, 0);
         chk("rst_err", err, 0);
         chk("rst_state", dbg_state, ST_IDLE);
`ifdef VPU_CAPTURE_CRC_EN
         chk("rst_crc", frame_crc, 0);
`endif
      end
      stop_pend = stop;
      rst_pend  = rst;
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1'b0, 1'b0, '0, -1);
   endtask

   task automatic pulse_start();
      req_start = 1'b1;
      tick(1'b0, 1'b0, '0, -1);
   endtask

   task automatic frame(input int nlines, input int short_line, input bit expect_wr,
                        input int start_line, input int stop_at, input int rst_at);
      int idx;
      int npx;
      logic [31:0] v;
      idx = 0;
      stop_at_g = stop_at;
      rst_at_g  = rst_at;
      idle(2);
      for (int l = 0; l < nlines; l++) begin
         if (l == start_line) req_start = 1'b1;
         repeat (2) tick(1'b0, 1'b1, '0, -1);
         npx = (l == short_line) ? 3 : SW;
         for (int p = 0; p < npx; p++) begin
            v = zero_col ? 32'd0 : 32'(pix_ctr);
            pix_ctr++;
            if (expect_wr && idx < SW*SH && idx < stop_at && idx < rst_at)
               exp_q.push_back({AW'(idx), v});
            tick(1'b1, 1'b1, v, idx);
            idx++;
         end
         repeat (2) tick(1'b0, 1'b1, '0, -1);
      end
      idle(8);
      stop_at_g = 1000;
      rst_at_g  = 1000;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      logic [31:0] crc_m;
      for (int i = 0; i < PL; i++) begin
         cpipe[i] = '0;
         ipipe[i] = -1;
      end

      // reset state
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_en", fb_en, 0);
      chk("reset_we", fb_we, 0);
      chk("reset_addr", fb_addr, 0);
      chk("reset_din", fb_din, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", frame_done, 0);
      chk("reset_err", err, 0);
      chk("reset_state", dbg_state, ST_IDLE);

      // basic frame: 8 writes, addr 0..7, data 0..7
      pix_ctr = 0;
      d0 = done_cnt;
      pulse_start();
      idle(3);
      chk("armed_busy", busy, 1);
      chk("armed_state", dbg_state, ST_ARMED);
      frame(2, -1, 1'b1, -1, 1000, 1000);
      chk("basic_done", done_cnt - d0, 1);
      chk("basic_err", err, 0);
      chk("basic_left", exp_q.size(), 0);
      chk("basic_idle", dbg_state, ST_IDLE);

      // start mid-frame: nothing until next vsync rise, then full frame from 0
      d0 = done_cnt;
      frame(2, -1, 1'b0, 1, 1000, 1000);
      chk("mid_wait_state", dbg_state, ST_ARMED);
      chk("mid_wait_done", done_cnt - d0, 0);
      frame(2, -1, 1'b1, -1, 1000, 1000);
      chk("mid_done", done_cnt - d0, 1);
      chk("mid_err", err, 0);
      chk("mid_left", exp_q.size(), 0);

      // short line sets sticky err, cleared by next start
      d0 = done_cnt;
      pulse_start();
      frame(2, 0, 1'b1, -1, 1000, 1000);
      chk("short_err", err, 1);
      chk("short_done", done_cnt - d0, 1);
      chk("short_left", exp_q.size(), 0);
      pulse_start();
      idle(1);
      chk("short_err_clr", err, 0);

      // stop during line 1 (DUT still armed from the start above)
      d0 = done_cnt;
      frame(2, -1, 1'b1, -1, 5, 1000);
      chk("stop_no_done", done_cnt - d0, 0);
      chk("stop_idle", dbg_state, ST_IDLE);
      chk("stop_left", exp_q.size(), 0);

      // three-line frame: writes past addr 7 suppressed, err set
      d0 = done_cnt;
      pulse_start();
      frame(3, -1, 1'b1, -1, 1000, 1000);
      chk("ovf_err", err, 1);
      chk("ovf_done", done_cnt - d0, 1);
      chk("ovf_left", exp_q.size(), 0);

      // continuous: two full frames, reset in the middle of the third
      continuous = 1'b1;
      d0 = done_cnt;
      pulse_start();
      frame(2, -1, 1'b1, -1, 1000, 1000);
      frame(2, -1, 1'b1, -1, 1000, 1000);
      chk("cont_done", done_cnt - d0, 2);
      chk("cont_rearmed", busy, 1);
      chk("cont_err", err, 0);
      frame(2, -1, 1'b1, -1, 1000, 5);
      chk("cont_rst_done", done_cnt - d0, 2);
      chk("cont_left", exp_q.size(), 0);
      continuous = 1'b0;

`ifdef VPU_CAPTURE_CRC_EN
      // CRC over an all-zero frame against a bitwise software model
      zero_col = 1'b1;
      pulse_start();
      frame(2, -1, 1'b1, -1, 1000, 1000);
      zero_col = 1'b0;
      crc_m = 32'hFFFF_FFFF;
      for (int w = 0; w < SW*SH; w++)
         for (int b = 31; b >= 0; b--)
            crc_m = crc_m[31] ? ((crc_m << 1) ^ 32'h04C1_1DB7) : (crc_m << 1);
      chk("crc_zero", frame_crc, crc_m);
      chk("crc_left", exp_q.size(), 0);
`else
      crc_m = '0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
